i2s_rate_sequencer: RTL and testbench

// APB master that reprograms the I2S clock controller's cmd_reg1 (addr 0) and cmd_reg2 (addr 4)
// for a new sample rate, glitch-safely.

---
 rtl/i2s_rate_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2s_rate_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rate_sequencer.sv
// i2s_rate_sequencer
// APB master that reprograms the I2S clock controller for a new sample rate.
// Sequence: quiesce (slave mode), settle, load LRCLK divisors, enable the
// final config, then read cmd_reg1 back to confirm it took.
module i2s_rate_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [1:0]  rate_sel,
    input  logic        master_mode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  cur_rate,
    output logic [4:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
    localparam logic [7:0]  TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  ADDR_CMD1   = 5'd0;
    localparam logic [4:0]  ADDR_CMD2   = 5'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_Q_SET,
        S_Q_ACC,
        S_SETTLE,
        S_D_SET,
        S_D_ACC,
        S_C_SET,
        S_C_ACC,
        S_R_SET,
        S_R_ACC,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  rate_q;
    logic        master_q;
    logic [15:0] settle_cnt_q;
    logic [7:0]  tmo_cnt_q;

    // cmd_reg1 value (master bit cleared) for a given rate
    function automatic logic [31:0] r1_of(input logic [1:0] r);
        case (r)
            2'd0:    return 32'h0003_0000;
            2'd1:    return 32'h0005_0002;
            2'd2:    return 32'h0001_0000;
            default: return 32'h0002_0002;
        endcase
    endfunction

    // cmd_reg2 (LRCLK divisors) for a given rate
    function automatic logic [31:0] r2_of(input logic [1:0] r);
        case (r)
            2'd0:    return 32'h0000_0F0F;
            2'd1:    return 32'h0000_1717;
            2'd2:    return 32'h0000_0707;
            default: return 32'h0000_0B0B;
        endcase
    endfunction

    logic [31:0] r1_in;     // from the live input, used only at acceptance
    logic [31:0] r1_lat;    // from the latched request
    logic [31:0] r2_lat;
    logic [31:0] cfg_final; // cmd_reg1 with the requested master bit
    logic        tmo_hit;

    assign r1_in     = r1_of(rate_sel);
    assign r1_lat    = r1_of(rate_q);
    assign r2_lat    = r2_of(rate_q);
    assign cfg_final = r1_lat | {31'b0, master_q};
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    // Sequencer FSM; all outputs registered so APB signals change only on clock edges
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rate_q       <= 2'd0;
            master_q     <= 1'b0;
            settle_cnt_q <= 16'd0;
            tmo_cnt_q    <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cur_rate     <= 2'd1;
            paddr        <= 5'd0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            pwdata       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        rate_q   <= rate_sel;
                        master_q <= master_mode;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        paddr    <= ADDR_CMD1;
                        pwrite   <= 1'b1;
                        pwdata   <= r1_in & 32'hFFFF_FFFE;
                        state_q  <= S_Q_SET;
                    end
                end
                S_Q_SET: begin
                    penable   <= 1'b1;
                    tmo_cnt_q <= 8'd0;
                    state_q   <= S_Q_ACC;
                end
                S_Q_ACC: begin
                    if (pready) begin
                        psel         <= 1'b0;
                        penable      <= 1'b0;
                        settle_cnt_q <= SETTLE_LOAD;
                        state_q      <= S_SETTLE;
                    end else if (tmo_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 16'd1) begin
                        psel    <= 1'b1;
                        paddr   <= ADDR_CMD2;
                        pwrite  <= 1'b1;
                        pwdata  <= r2_lat;
                        state_q <= S_D_SET;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 16'd1;
                    end
                end
                S_D_SET: begin
                    penable   <= 1'b1;
                    tmo_cnt_q <= 8'd0;
                    state_q   <= S_D_ACC;
                end
                S_D_ACC: begin
                    if (pready) begin
                        penable <= 1'b0;
                        paddr   <= ADDR_CMD1;
                        pwrite  <= 1'b1;
                        pwdata  <= cfg_final;
                        state_q <= S_C_SET;
                    end else if (tmo_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_C_SET: begin
                    penable   <= 1'b1;
                    tmo_cnt_q <= 8'd0;
                    state_q   <= S_C_ACC;
                end
                S_C_ACC: begin
                    if (pready) begin
                        penable <= 1'b0;
                        paddr   <= ADDR_CMD1;
                        pwrite  <= 1'b0;
                        state_q <= S_R_SET;
                    end else if (tmo_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_R_SET: begin
                    penable   <= 1'b1;
                    tmo_cnt_q <= 8'd0;
                    state_q   <= S_R_ACC;
                end
                S_R_ACC: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        done    <= 1'b1;
                        // Only commit the new rate if the controller really holds it
                        if (prdata == cfg_final) begin
                            cur_rate <= rate_q;
                        end else begin
                            err <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end else if (tmo_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rate_sequencer.sv
// Directed bench for i2s_rate_sequencer with an APB slave model and a
// transfer scoreboard.
module tb_i2s_rate_sequencer;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [1:0]  rate_sel;
    logic        master_mode;
    logic        busy, done, err;
    logic [1:0]  cur_rate;
    logic [4:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    always #5 clk = ~clk;

    i2s_rate_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rate_sel(rate_sel),
        .master_mode(master_mode), .busy(busy), .done(done), .err(err),
        .cur_rate(cur_rate), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t sb_q[$];

    // slave model state
    logic [31:0] reg0 = 32'h0005_0003;
    int   wcnt = 0;
    int   d_waits = 0;
    bit   stuck = 0;
    bit   corrupt = 0;
    int   acc_run = 0;
    int   d_acc = 0;
    logic [4:0]  set_addr;
    logic        set_wr;
    logic [31:0] set_data;
    int   waits_now;

    assign waits_now = (pwrite && paddr == 5'd4) ? d_waits : 0;
    assign pready = psel && penable && !stuck && (wcnt >= waits_now);
    assign prdata = corrupt ? 32'hDEADBEEF : reg0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // APB slave + scoreboard monitor
    always @(posedge clk) begin
        if (!reset_n) begin
            acc_run <= 0;
            wcnt    <= 0;
        end else if (psel && !penable) begin
            acc_run  <= 0;
            wcnt     <= 0;
            set_addr <= paddr;
            set_wr   <= pwrite;
            set_data <= pwdata;
        end else if (psel && penable) begin
            acc_run <= acc_run + 1;
            chk("acc_stable_addr", 32'(paddr), 32'(set_addr));
            chk("acc_stable_wr", 32'(pwrite), 32'(set_wr));
            if (pwrite) chk("acc_stable_data", pwdata, set_data);
            if (pready) begin
                xfer_t e;
                wcnt <= 0;
                if (pwrite && paddr == 5'd4) d_acc <= acc_run + 1;
                if (pwrite && paddr == 5'd0) reg0 <= pwdata;
                $display("xfer %s addr=%0d data=0x%08h", pwrite ? "WR" : "RD", paddr,
                         pwrite ? pwdata : prdata);
                if (sb_q.size() == 0) begin
                    chk("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_dir", 32'(pwrite), 32'(e.wr));
                    chk("xfer_addr", 32'(paddr), 32'(e.addr));
                    if (e.wr) chk("xfer_wdata", pwdata, e.data);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    function automatic logic [31:0] tbl_r1(input logic [1:0] r);
        case (r)
            2'd0:    return 32'h0003_0000;
            2'd1:    return 32'h0005_0002;
            2'd2:    return 32'h0001_0000;
            default: return 32'h0002_0002;
        endcase
    endfunction

    function automatic logic [31:0] tbl_r2(input logic [1:0] r);
        case (r)
            2'd0:    return 32'h0000_0F0F;
            2'd1:    return 32'h0000_1717;
            2'd2:    return 32'h0000_0707;
            default: return 32'h0000_0B0B;
        endcase
    endfunction

    task automatic push_seq(input logic [1:0] rs, input logic mm);
        sb_q.push_back('{1'b1, 5'd0, tbl_r1(rs)});
        sb_q.push_back('{1'b1, 5'd4, tbl_r2(rs)});
        sb_q.push_back('{1'b1, 5'd0, tbl_r1(rs) | {31'b0, mm}});
        sb_q.push_back('{1'b0, 5'd0, 32'd0});
    endtask

    task automatic run_req(input logic [1:0] rs, input logic mm, input bit do_push,
                           input int exp_lat, input logic exp_err,
                           input logic [1:0] exp_rate, input bit pulse);
        int e0;
        int lat;
        bit seen;
        if (do_push) push_seq(rs, mm);
        @(posedge clk); #1;
        req = 1'b1; rate_sel = rs; master_mode = mm;
        @(posedge clk); #1;
        e0 = cyc;
        req = 1'b0; rate_sel = ~rs; master_mode = ~mm;
        chk("busy_after_accept", 32'(busy), 32'd1);
        seen = 0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                lat = cyc - e0;
                break;
            end
            if (pulse && k == 3) begin req = 1'b1; rate_sel = 2'd2; end
            if (pulse && k == 4) req = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("err", 32'(err), 32'(exp_err));
        chk("cur_rate", 32'(cur_rate), 32'(exp_rate));
        chk("psel_in_done", 32'(psel), 32'd0);
        $display("req rate=%0d mm=%0d lat=%0d err=%0d cur_rate=%0d", rs, mm, lat, err, cur_rate);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = 1'b0; rate_sel = 2'd0; master_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cur_rate", 32'(cur_rate), 32'd1);
        reset_n = 1'b1;

        // zero-wait sequence
        run_req(2'd0, 1'b1, 1'b1, 8 + SETTLE, 1'b0, 2'd0, 1'b0);

        // wait states on the divisor write
        d_waits = 3;
        run_req(2'd1, 1'b1, 1'b1, 8 + SETTLE + 3, 1'b0, 2'd1, 1'b0);
        chk("d_acc_cycles", 32'(d_acc), 32'd4);
        d_waits = 0;

        // slave never answers the quiesce write
        stuck = 1'b1;
        run_req(2'd3, 1'b1, 1'b0, 1 + TMO, 1'b1, 2'd1, 1'b0);
        chk("tmo_acc_cycles", 32'(acc_run), 32'(TMO));
        stuck = 1'b0;
        repeat (5) @(posedge clk);

        // bad readback, then a good request clears err
        corrupt = 1'b1;
        run_req(2'd3, 1'b0, 1'b1, 8 + SETTLE, 1'b1, 2'd1, 1'b0);
        corrupt = 1'b0;
        run_req(2'd2, 1'b0, 1'b1, 8 + SETTLE, 1'b0, 2'd2, 1'b0);

        // req pulsed during SETTLE is dropped
        run_req(2'd0, 1'b1, 1'b1, 8 + SETTLE, 1'b0, 2'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_requeue_busy", 32'(busy), 32'd0);

        // reset in the middle of the enable write
        push_seq(2'd3, 1'b1);
        @(posedge clk); #1;
        req = 1'b1; rate_sel = 2'd3; master_mode = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("c_acc_penable", 32'(penable), 32'd1);
        chk("c_acc_wdata", pwdata, 32'h0002_0003);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_penable", 32'(penable), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cur_rate", 32'(cur_rate), 32'd1);
        chk("mid_rst_err", 32'(err), 32'd0);
        $display("reset during C_ACC psel=%0d busy=%0d cur_rate=%0d", psel, busy, cur_rate);
        sb_q.delete();
        reset_n = 1'b1;
        run_req(2'd3, 1'b1, 1'b1, 8 + SETTLE, 1'b0, 2'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
